// File: rtl/scan_pkg.sv
// Shared types for the scan select sequencer: slot index, mask, FSM states
// and the cyclic next-set-bit search used by the skip build.
package scan_pkg;

  localparam int SLOT_W    = 2;
  localparam int NUM_SLOTS = 4;

  typedef logic [SLOT_W-1:0]    slot_t;
  typedef logic [NUM_SLOTS-1:0] mask_t;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  typedef struct packed {
    logic  ok;
    slot_t idx;
  } pick_t;

  // Search starts after cur and ends on cur itself, so a lone set bit
  // selects the same slot again.
  function automatic pick_t next_set(mask_t m, slot_t cur);
    pick_t p;
    slot_t c;
    p.ok  = 1'b0;
    p.idx = cur;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      c = cur + slot_t'(k);
      if (!p.ok && m[c]) begin
        p.ok  = 1'b1;
        p.idx = c;
      end
    end
    return p;
  endfunction

  function automatic pick_t first_set(mask_t m);
    return next_set(m, slot_t'(NUM_SLOTS - 1));
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot cycle counter: counts up from 0, cleared by clr or rst.
// Ports: clk, rst, clr in; blank_done, drive_pre, drive_done out.
module scan_slot_timer #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic blank_done,
  output logic drive_pre,
  output logic drive_done
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] B_LAST =
    CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [CW-1:0] D_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] D_PRE  =
    CW'((DIV >= 2) ? DIV - 2 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else            cnt <= cnt + CW'(1);
  end

  assign blank_done = (cnt == B_LAST);
  assign drive_done = (cnt == D_LAST);
  // One cycle ahead of drive_done so frame_done can be registered.
  assign drive_pre  = (DIV >= 2) && (cnt == D_PRE);

endmodule

// File: rtl/scan_select_sequencer.sv
// Steps {W1,W0} through slots 0..3 with a blanking gap before each slot.
// Ports: clk, rst, run, digit_mask[3:0] in; W0, W1, En, slot_start,
// frame_done out. Define SCAN_SKIP_EN to skip masked slots entirely.
module scan_select_sequencer
  import scan_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] digit_mask,
  output logic       W0,
  output logic       W1,
  output logic       En,
  output logic       slot_start,
  output logic       frame_done
);

  state_t state;
  slot_t  idx;
  mask_t  mask_q;

  logic   clr;
  logic   blank_done;
  logic   drive_pre;
  logic   drive_done;

  pick_t  first_pk;
  pick_t  cur_nx;
  pick_t  ent_nx;
  slot_t  ent_idx;
  mask_t  ent_mask;
  logic   cur_en;
  logic   ent_en;
  logic   cur_wrap;
  logic   ent_wrap;

  scan_slot_timer #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .blank_done (blank_done),
    .drive_pre  (drive_pre),
    .drive_done (drive_done)
  );

  // ent_* describe the slot that the next DRIVE entry would run, used
  // when DRIVE is entered without a BLANK in between.
  always_comb begin
    ent_idx  = idx;
    ent_mask = mask_q;
    if (state == IDLE) begin
      ent_idx  = first_pk.idx;
      ent_mask = digit_mask;
    end else if (state == DRIVE) begin
      ent_idx  = cur_nx.idx;
      ent_mask = digit_mask;
    end
  end

`ifdef SCAN_SKIP_EN
  assign first_pk = first_set(digit_mask);
  assign cur_nx   = next_set(mask_q, idx);
  assign ent_nx   = next_set(ent_mask, ent_idx);
  assign cur_en   = 1'b1;
  assign ent_en   = 1'b1;
`else
  assign first_pk = '{ok: 1'b1, idx: '0};
  assign cur_nx   = '{ok: 1'b1, idx: slot_t'(idx + 1'b1)};
  assign ent_nx   = '{ok: 1'b1, idx: slot_t'(ent_idx + 1'b1)};
  assign cur_en   = mask_q[idx];
  assign ent_en   = ent_mask[ent_idx];
`endif

  assign cur_wrap = cur_nx.ok && (cur_nx.idx <= idx);
  assign ent_wrap = ent_nx.ok && (ent_nx.idx <= ent_idx);

  always_comb begin
    unique case (state)
      IDLE:    clr = 1'b1;
      BLANK:   clr = blank_done;
      DRIVE:   clr = drive_done;
      default: clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      mask_q     <= '0;
      En         <= 1'b0;
      slot_start <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      slot_start <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          En <= 1'b0;
          if (run && first_pk.ok) begin
            idx    <= first_pk.idx;
            mask_q <= digit_mask;
            if (BLANK_CYC == 0) begin
              state      <= DRIVE;
              En         <= ent_en;
              slot_start <= 1'b1;
              frame_done <= (DIV == 1) && ent_wrap;
            end else begin
              state <= BLANK;
            end
          end
        end
        BLANK: begin
          En <= 1'b0;
          if (blank_done) begin
            state      <= DRIVE;
            En         <= cur_en;
            slot_start <= 1'b1;
            frame_done <= (DIV == 1) && cur_wrap;
          end
        end
        DRIVE: begin
          if (drive_pre) frame_done <= cur_wrap;
          if (drive_done) begin
            if (run && cur_nx.ok) begin
              idx    <= cur_nx.idx;
              mask_q <= digit_mask;
              if (BLANK_CYC == 0) begin
                En         <= ent_en;
                slot_start <= 1'b1;
                frame_done <= (DIV == 1) && ent_wrap;
              end else begin
                state <= BLANK;
                En    <= 1'b0;
              end
            end else begin
              state <= IDLE;
              En    <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          En    <= 1'b0;
        end
      endcase
    end
  end

  assign W0 = idx[0];
  assign W1 = idx[1];

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Scoreboard bench: expected per-cycle {W1,W0,En,slot_start,frame_done}
// vectors are queued from a slot schedule and popped each cycle.
module tb_scan_select_sequencer;
  localparam int DIV = 4;
  localparam int BLK = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       run0 = 1'b0;
  logic [3:0] digit_mask = 4'hF;

  logic W0, W1, En, slot_start, frame_done;
  logic b_W0, b_W1, b_En, b_slot_start, b_frame_done;

  int checks = 0;
  int errors = 0;

  logic [4:0] q[$];

  always #5 clk = ~clk;

  scan_select_sequencer #(.DIV(DIV), .BLANK_CYC(BLK)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .digit_mask (digit_mask),
    .W0         (W0),
    .W1         (W1),
    .En         (En),
    .slot_start (slot_start),
    .frame_done (frame_done)
  );

  scan_select_sequencer #(.DIV(DIV), .BLANK_CYC(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .run        (run0),
    .digit_mask (digit_mask),
    .W0         (b_W0),
    .W1         (b_W1),
    .En         (b_En),
    .slot_start (b_slot_start),
    .frame_done (b_frame_done)
  );

  task automatic push_slot(input int idx, input bit en, input bit fd,
                           input int nblank);
    logic [1:0] w;
    w = idx[1:0];
    repeat (nblank) q.push_back({w, 3'b000});
    for (int k = 0; k < DIV; k++)
      q.push_back({w, en, k == 0, fd && (k == DIV - 1)});
  endtask

  task automatic push_idle(input logic [1:0] w, input int n);
    repeat (n) q.push_back({w, 3'b000});
  endtask

  task automatic test_reset;
    int c;
    logic [4:0] e, o;
    rst = 1'b1;
    run = 1'b0;
    push_idle(2'd0, 12);
    c = 0;
    while (q.size() > 0) begin
      if (c == 2) rst = 1'b0;
      @(posedge clk); #1;
      e = q.pop_front();
      o = {W1, W0, En, slot_start, frame_done};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset cyc %0d got %b want %b", c, o, e);
      end
      c++;
    end
  endtask

  task automatic test_scan;
    int c;
    logic [4:0] e, o;
    run = 1'b1;
    for (int s = 0; s < 5; s++)
      push_slot(s % 4, 1'b1, s == 3, BLK);
    c = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      o = {W1, W0, En, slot_start, frame_done};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL scan cyc %0d got %b want %b", c, o, e);
      end
      c++;
    end
  endtask

  task automatic test_stop;
    int c;
    logic [4:0] e, o;
    push_slot(1, 1'b1, 1'b0, BLK);
    push_idle(2'd1, 8);
    c = 0;
    while (q.size() > 0) begin
      if (c == 3) run = 1'b0;
      @(posedge clk); #1;
      e = q.pop_front();
      o = {W1, W0, En, slot_start, frame_done};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stop cyc %0d got %b want %b", c, o, e);
      end
      c++;
    end
  endtask

  task automatic test_mask;
    int c, n;
    logic [4:0] e, o;
    digit_mask = 4'b0101;
    run = 1'b1;
`ifdef SCAN_SKIP_EN
    push_slot(0, 1'b1, 1'b0, BLK);
    push_slot(2, 1'b1, 1'b1, BLK);
    push_slot(0, 1'b1, 1'b0, BLK);
    push_slot(2, 1'b1, 1'b1, BLK);
`else
    push_slot(0, 1'b1, 1'b0, BLK);
    push_slot(1, 1'b0, 1'b0, BLK);
    push_slot(2, 1'b1, 1'b0, BLK);
    push_slot(3, 1'b0, 1'b1, BLK);
    push_slot(0, 1'b1, 1'b0, BLK);
`endif
    n = q.size();
    push_idle(2'd0, 1);
    c = 0;
    while (q.size() > 0) begin
      if (c == n) begin
        rst = 1'b1;
        run = 1'b0;
      end
      @(posedge clk); #1;
      e = q.pop_front();
      o = {W1, W0, En, slot_start, frame_done};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mask cyc %0d got %b want %b", c, o, e);
      end
      c++;
    end
    rst = 1'b0;
    digit_mask = 4'hF;
  endtask

  task automatic test_reset_mid;
    int c;
    logic [4:0] e, o;
    run = 1'b1;
    push_slot(0, 1'b1, 1'b0, BLK);
    push_slot(1, 1'b1, 1'b0, BLK);
    q.push_back({2'd2, 3'b000});
    for (int k = 0; k < 3; k++) q.push_back({2'd2, 1'b1, k == 0, 1'b0});
    push_idle(2'd0, 1);
    push_slot(0, 1'b1, 1'b0, BLK);
    push_idle(2'd0, 1);
    c = 0;
    while (q.size() > 0) begin
      if (c == 14) rst = 1'b1;
      if (c == 15) rst = 1'b0;
      if (c == 20) begin
        rst = 1'b1;
        run = 1'b0;
      end
      @(posedge clk); #1;
      e = q.pop_front();
      o = {W1, W0, En, slot_start, frame_done};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rstmid cyc %0d got %b want %b", c, o, e);
      end
      c++;
    end
    rst = 1'b0;
  endtask

  task automatic test_w_stable;
    logic [1:0] pw;
    logic       pe;
    int         seen;
    run = 1'b1;
    pw = {W1, W0};
    pe = En;
    seen = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (pe && En) begin
        seen++;
        checks++;
        if ({W1, W0} !== pw) begin
          errors++;
          $display("FAIL wstable cyc %0d got %b want %b", c, {W1, W0}, pw);
        end
      end
      pw = {W1, W0};
      pe = En;
    end
    checks++;
    if (seen != 27) begin
      errors++;
      $display("FAIL wstable_count got %0d want %0d", seen, 27);
    end
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_blank0;
    int c, n;
    logic [4:0] e, o;
    run0 = 1'b1;
    for (int s = 0; s < 5; s++)
      push_slot(s % 4, 1'b1, s == 3, 0);
    n = q.size();
    push_idle(2'd0, 1);
    c = 0;
    while (q.size() > 0) begin
      if (c == n) begin
        rst = 1'b1;
        run0 = 1'b0;
      end
      @(posedge clk); #1;
      e = q.pop_front();
      o = {b_W1, b_W0, b_En, b_slot_start, b_frame_done};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL blank0 cyc %0d got %b want %b", c, o, e);
      end
      c++;
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_scan;
    test_stop;
    test_mask;
    test_reset_mid;
    test_w_stable;
    test_blank0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
